neuron_seq_ctrl: RTL and testbench
==================================

Name: neuron_seq_ctrl

Overview:
Sequencer for one serial neuron datapath: a single shared multiplier, an accumulator and an external sigmoid unit.
- Forward pass: on a start request, fetches NUM weights and the bias from the weight store one word per cycle, multiply-accumulates them against latched inputs, then captures the activation.
- Weight update: arbitrates write-back of updated weights/bias into the weight store, so that reads and writes never overlap.

Parameters:
NUM, 3, number of inputs/weights per neuron
WIDTH, 32, signed word width of inputs, weights, bias, sum, activation
AW, 4, weight-store address width; must satisfy 2^AW > NUM

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
i_start  in  1  forward-pass request, sampled only in IDLE
i_k  in  NUM*WIDTH  inputs; slice j = [j*WIDTH +: WIDTH]; latched when start is accepted
o_busy  out  1  high in every state except IDLE
o_done  out  1  one-cycle pulse; o_a valid
o_addr  out  AW  weight-store read address; 0..NUM-1 = weights, NUM = bias
o_rd  out  1  read strobe; data returns on i_wght next cycle
i_wght  in  WIDTH  weight-store read data, 1-cycle latency
o_mac_a  out  WIDTH  multiplier operand: latched input slice idx
o_mac_b  out  WIDTH  multiplier operand: i_wght
i_mac_p  in  WIDTH  combinational product from shared multiplier, already scaled to WIDTH
o_sum  out  WIDTH  registered accumulator, drives sigmoid input
i_act  in  WIDTH  combinational sigmoid output
o_a  out  WIDTH  registered activation
i_upd_req  in  1  weight-update request, level; held until ack
i_upd_w  in  NUM*WIDTH  new weights
i_upd_b  in  WIDTH  new bias
o_upd_ack  out  1  one-cycle pulse when update is written
o_wr  out  1  weight-store write strobe, one cycle
o_wr_w  out  NUM*WIDTH  registered write data, weights
o_wr_b  out  WIDTH  registered write data, bias

Behaviour:
- Reset (async, any state): state=IDLE, idx=0, acc=0. All outputs 0, including o_a, o_sum, o_wr_w, o_wr_b. An in-flight pass is aborted: no o_done, no o_wr.
- States: IDLE, FETCH, MAC, BIAS, ACT, DONE, UPD.
- IDLE:
  - i_upd_req=1 -> UPD; latch i_upd_w/i_upd_b into o_wr_w/o_wr_b. Update has priority over a simultaneous i_start.
  - Else i_start=1 -> FETCH; latch i_k, acc=0, idx=0.
- FETCH: o_rd=1, o_addr=0 -> MAC.
- MAC (NUM cycles, idx=0..NUM-1):
  - o_mac_a=k[idx], o_mac_b=i_wght; acc <= acc + i_mac_p.
  - o_rd=1, o_addr=idx+1 (the last MAC cycle addresses the bias at NUM).
  - idx==NUM-1 -> BIAS, else idx++.
- BIAS: acc <= acc + i_wght; o_rd=0 -> ACT.
- ACT: o_sum holds final acc; o_a <= i_act -> DONE.
- DONE: o_done=1 for one cycle -> IDLE.
- UPD: o_wr=1 and o_upd_ack=1 for one cycle -> IDLE.
- o_sum mirrors acc at all times (registered). o_a holds its value until the next ACT.
- Latency: start accepted at edge 0 -> o_done high in cycle NUM+4 (7 for NUM=3). Update: ack in the cycle after acceptance.
- i_start while busy: ignored, not queued.
- i_upd_req while busy: stalls until IDLE, then served before any new start.
- o_rd and o_wr are never high in the same cycle.
- Arithmetic: signed two's complement, WIDTH bits; wraps on overflow (see the optional feature).

Optional Feature:
ACC_SAT_EN
- Defined: every accumulate (MAC and BIAS) saturates to 2^(WIDTH-1)-1 / -2^(WIDTH-1) on signed overflow.
- Undefined: plain wrap-around addition.

Test Plan:
Bench stubs: multiplier returns the low WIDTH bits of a*b; sigmoid returns i+1; weight store is a 1-cycle-latency RAM.
- Basic pass: w={4,5,6}, b=7, i_k={1,2,3}, start pulse -> o_addr sequence 0,1,2,3; o_sum=0x27; o_a=0x28; o_done exactly at cycle 7; o_busy high cycles 1-6.
- Update then read: i_upd_req with w={1,1,1}, b=0 -> o_wr and o_upd_ack at cycle 1. Then start with i_k={2,3,4} -> o_sum=9, o_a=10.
- Simultaneous i_start and i_upd_req in IDLE -> UPD served first. Start dropped unless reasserted. Request held during a pass -> ack comes only after o_done.
- Overflow: w={0x7FFFFFFF,1,0}, b=0, i_k={1,1,0} -> o_sum=0x80000000 without ACC_SAT_EN, 0x7FFFFFFF with it.
- Reset at cycle 4 of a pass -> all outputs 0 immediately, no o_done. A subsequent start completes normally.
- i_start pulsed at cycles 2 and 5 of a pass -> ignored; exactly one o_done.

Source files
------------

// File: rtl/neuron_seq_if.sv
// Handshake and bus bundle between the neuron sequencer and its datapath,
// weight store and update source.
interface neuron_seq_if #(
    parameter int NUM   = 3,
    parameter int WIDTH = 32,
    parameter int AW    = 4
);
    logic                   i_start;
    logic [NUM*WIDTH-1:0]   i_k;
    logic                   o_busy;
    logic                   o_done;
    logic [AW-1:0]          o_addr;
    logic                   o_rd;
    logic [WIDTH-1:0]       i_wght;
    logic [WIDTH-1:0]       o_mac_a;
    logic [WIDTH-1:0]       o_mac_b;
    logic [WIDTH-1:0]       i_mac_p;
    logic [WIDTH-1:0]       o_sum;
    logic [WIDTH-1:0]       i_act;
    logic [WIDTH-1:0]       o_a;
    logic                   i_upd_req;
    logic [NUM*WIDTH-1:0]   i_upd_w;
    logic [WIDTH-1:0]       i_upd_b;
    logic                   o_upd_ack;
    logic                   o_wr;
    logic [NUM*WIDTH-1:0]   o_wr_w;
    logic [WIDTH-1:0]       o_wr_b;

    modport master (
        input  i_start, i_k, i_wght, i_mac_p, i_act, i_upd_req, i_upd_w, i_upd_b,
        output o_busy, o_done, o_addr, o_rd, o_mac_a, o_mac_b, o_sum, o_a,
               o_upd_ack, o_wr, o_wr_w, o_wr_b
    );

    modport slave (
        output i_start, i_k, i_wght, i_mac_p, i_act, i_upd_req, i_upd_w, i_upd_b,
        input  o_busy, o_done, o_addr, o_rd, o_mac_a, o_mac_b, o_sum, o_a,
               o_upd_ack, o_wr, o_wr_w, o_wr_b
    );
endinterface

// File: rtl/neuron_seq_ctrl.sv
// Serial neuron sequencer: fetch/MAC/bias/activation pass plus weight-store write-back.
// Define ACC_SAT_EN to make every accumulate saturate instead of wrapping.
module neuron_seq_ctrl #(
    parameter int NUM   = 3,
    parameter int WIDTH = 32,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          rst,
    neuron_seq_if.master  bus
);
    localparam int IW = (NUM > 1) ? $clog2(NUM) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_MAC, S_BIAS, S_ACT, S_DONE, S_UPD
    } state_t;

    state_t                      state_q, state_d;
    logic [IW-1:0]               idx_q, idx_d;
    logic [WIDTH-1:0]            acc_q, acc_d;
    logic [NUM-1:0][WIDTH-1:0]   k_q, k_d;
    logic [WIDTH-1:0]            a_q, a_d;
    logic [NUM*WIDTH-1:0]        wr_w_q, wr_w_d;
    logic [WIDTH-1:0]            wr_b_q, wr_b_d;
    logic                        rd;
    logic [AW-1:0]               addr;
    logic [WIDTH-1:0]            mac_a, mac_b;

    function automatic logic [WIDTH-1:0] acc_add(input logic [WIDTH-1:0] x,
                                                 input logic [WIDTH-1:0] y);
        logic [WIDTH-1:0] s;
        s = x + y;
`ifdef ACC_SAT_EN
        // Overflow only when both operands share a sign the result lacks.
        if ((x[WIDTH-1] == y[WIDTH-1]) && (s[WIDTH-1] != x[WIDTH-1]))
            s = x[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`endif
        return s;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            acc_q   <= '0;
            k_q     <= '0;
            a_q     <= '0;
            wr_w_q  <= '0;
            wr_b_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            k_q     <= k_d;
            a_q     <= a_d;
            wr_w_q  <= wr_w_d;
            wr_b_q  <= wr_b_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        k_d     = k_q;
        a_d     = a_q;
        wr_w_d  = wr_w_q;
        wr_b_d  = wr_b_q;
        rd      = 1'b0;
        addr    = '0;
        mac_a   = '0;
        mac_b   = '0;
        case (state_q)
            S_IDLE: begin
                // Pending update wins so reads and writes never interleave.
                if (bus.i_upd_req) begin
                    state_d = S_UPD;
                    wr_w_d  = bus.i_upd_w;
                    wr_b_d  = bus.i_upd_b;
                end else if (bus.i_start) begin
                    state_d = S_FETCH;
                    k_d     = bus.i_k;
                    acc_d   = '0;
                    idx_d   = '0;
                end
            end
            S_FETCH: begin
                rd      = 1'b1;
                addr    = '0;
                state_d = S_MAC;
            end
            S_MAC: begin
                mac_a = k_q[idx_q];
                mac_b = bus.i_wght;
                acc_d = acc_add(acc_q, bus.i_mac_p);
                rd    = 1'b1;
                // Prefetch the next word; the last MAC cycle addresses the bias.
                addr  = AW'(idx_q) + AW'(1);
                if (idx_q == IW'(NUM-1)) begin
                    state_d = S_BIAS;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            S_BIAS: begin
                acc_d   = acc_add(acc_q, bus.i_wght);
                state_d = S_ACT;
            end
            S_ACT: begin
                a_d     = bus.i_act;
                state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            S_UPD:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.o_busy    = (state_q != S_IDLE);
    assign bus.o_done    = (state_q == S_DONE);
    assign bus.o_upd_ack = (state_q == S_UPD);
    assign bus.o_wr      = (state_q == S_UPD);
    assign bus.o_rd      = rd;
    assign bus.o_addr    = addr;
    assign bus.o_mac_a   = mac_a;
    assign bus.o_mac_b   = mac_b;
    assign bus.o_sum     = acc_q;
    assign bus.o_a       = a_q;
    assign bus.o_wr_w    = wr_w_q;
    assign bus.o_wr_b    = wr_b_q;
endmodule

// File: tb/tb_neuron_seq_ctrl.sv
// Directed bench for neuron_seq_ctrl with multiplier, sigmoid (x+1) and 1-cycle RAM stubs.
// Honours ACC_SAT_EN for the overflow expectations.
module tb_neuron_seq_ctrl;
    localparam int NUM = 3;
    localparam int W   = 32;
    localparam int AW  = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    neuron_seq_if #(.NUM(NUM), .WIDTH(W), .AW(AW)) bus ();

    neuron_seq_ctrl #(.NUM(NUM), .WIDTH(W), .AW(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    logic [W-1:0] mem [0:(1<<AW)-1];
    logic [W-1:0] rdata;
    always @(posedge clk) begin
        if (bus.o_rd) rdata <= mem[bus.o_addr];
        if (bus.o_wr) begin
            for (int j = 0; j < NUM; j++) mem[j] <= bus.o_wr_w[j*W +: W];
            mem[NUM] <= bus.o_wr_b;
        end
    end
    assign bus.i_wght  = rdata;
    assign bus.i_mac_p = bus.o_mac_a * bus.o_mac_b;
    assign bus.i_act   = bus.o_sum + 32'd1;

    typedef struct {
        logic [NUM-1:0][W-1:0] w;
        logic [W-1:0]          b;
        logic [NUM-1:0][W-1:0] k;
        logic [W-1:0]          es;
        logic [W-1:0]          ea;
    } vec_t;
    vec_t tbl [4];

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string nm, input logic [NUM*W-1:0] act, input logic [NUM*W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, " busy"},  bus.o_busy, 0);
        check({tag, " done"},  bus.o_done, 0);
        check({tag, " rd"},    bus.o_rd, 0);
        check({tag, " addr"},  bus.o_addr, 0);
        check({tag, " wr"},    bus.o_wr, 0);
        check({tag, " ack"},   bus.o_upd_ack, 0);
        check({tag, " sum"},   bus.o_sum, 0);
        check({tag, " a"},     bus.o_a, 0);
        check({tag, " wr_w"},  bus.o_wr_w, 0);
        check({tag, " wr_b"},  bus.o_wr_b, 0);
    endtask

    task automatic do_upd(input logic [NUM-1:0][W-1:0] w, input logic [W-1:0] b, input string tag);
        bus.i_upd_req = 1'b1;
        bus.i_upd_w   = w;
        bus.i_upd_b   = b;
        step();
        check({tag, " upd ack"},  bus.o_upd_ack, 1);
        check({tag, " upd wr"},   bus.o_wr, 1);
        check({tag, " upd wr_w"}, bus.o_wr_w, w);
        check({tag, " upd wr_b"}, bus.o_wr_b, b);
        bus.i_upd_req = 1'b0;
        step();
        check({tag, " upd ack low"}, bus.o_upd_ack, 0);
    endtask

    // mode 0: plain; 1: stray start pulses at cycles 2,5; 2: update request raised at cycle 2
    task automatic run_pass(input logic [NUM-1:0][W-1:0] k, input logic [NUM-1:0][W-1:0] uw,
                            input logic [W-1:0] ub, input logic [W-1:0] es, input logic [W-1:0] ea,
                            input int mode, input string tag);
        int ndone = 0;
        int last  = (mode == 2) ? 10 : 8;
        bus.i_k     = k;
        bus.i_start = 1'b1;
        for (int c = 1; c <= last; c++) begin
            step();
            if (bus.o_done) ndone++;
            check({tag, " rd&wr exclusive"}, bus.o_rd & bus.o_wr, 0);
            check($sformatf("%s done@%0d", tag, c), bus.o_done, (c == 7));
            if (c <= 4) begin
                check($sformatf("%s rd@%0d", tag, c), bus.o_rd, 1);
                check($sformatf("%s addr@%0d", tag, c), bus.o_addr, c-1);
            end else if (c <= 6) begin
                check($sformatf("%s rd@%0d", tag, c), bus.o_rd, 0);
            end
            if (c <= 6) check($sformatf("%s busy@%0d", tag, c), bus.o_busy, 1);
            if (c == 7) begin
                check({tag, " sum"}, bus.o_sum, es);
                check({tag, " a"},   bus.o_a, ea);
            end
            if (c == 8 && mode != 2) check({tag, " idle after done"}, bus.o_busy, 0);
            if (mode == 2) check($sformatf("%s ack@%0d", tag, c), bus.o_upd_ack, (c == 9));
            bus.i_start = (mode == 1 && (c == 2 || c == 5));
            if (mode == 2 && c == 2) begin
                bus.i_upd_req = 1'b1;
                bus.i_upd_w   = uw;
                bus.i_upd_b   = ub;
            end
            if (mode == 2 && c == 9) bus.i_upd_req = 1'b0;
        end
        bus.i_start = 1'b0;
        check({tag, " done count"}, ndone, 1);
        step();
    endtask

    initial begin
        int nd;
        bus.i_start   = 1'b0;
        bus.i_k       = '0;
        bus.i_upd_req = 1'b0;
        bus.i_upd_w   = '0;
        bus.i_upd_b   = '0;

        tbl[0] = '{w: {32'd6, 32'd5, 32'd4}, b: 32'd7, k: {32'd3, 32'd2, 32'd1},
                   es: 32'h27, ea: 32'h28};
        tbl[1] = '{w: {32'd1, 32'd1, 32'd1}, b: 32'd0, k: {32'd4, 32'd3, 32'd2},
                   es: 32'd9, ea: 32'd10};
        tbl[2] = '{w: {32'hFFFFFFFC, 32'd3, 32'hFFFFFFFE}, b: 32'hFFFFFFF6,
                   k: {32'd7, 32'hFFFFFFFA, 32'd5}, es: 32'hFFFFFFBE, ea: 32'hFFFFFFBF};
`ifdef ACC_SAT_EN
        tbl[3] = '{w: {32'd0, 32'd1, 32'h7FFFFFFF}, b: 32'd0, k: {32'd0, 32'd1, 32'd1},
                   es: 32'h7FFFFFFF, ea: 32'h80000000};
`else
        tbl[3] = '{w: {32'd0, 32'd1, 32'h7FFFFFFF}, b: 32'd0, k: {32'd0, 32'd1, 32'd1},
                   es: 32'h80000000, ea: 32'h80000001};
`endif

        #1;
        check_zero("reset");
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        step();
        check_zero("post-reset");

        for (int v = 0; v < 4; v++) begin
            do_upd(tbl[v].w, tbl[v].b, $sformatf("vec%0d", v));
            run_pass(tbl[v].k, '0, '0, tbl[v].es, tbl[v].ea, 0, $sformatf("vec%0d", v));
        end

        // Update requested mid-pass is held off until the pass completes.
        do_upd(tbl[0].w, tbl[0].b, "reload");
        run_pass(tbl[0].k, tbl[0].w, tbl[0].b, tbl[0].es, tbl[0].ea, 2, "held-upd");

        // Start pulses while busy are dropped.
        run_pass(tbl[0].k, '0, '0, tbl[0].es, tbl[0].ea, 1, "stray-start");

        // Simultaneous start and update: update first, start not queued.
        bus.i_upd_req = 1'b1;
        bus.i_upd_w   = tbl[0].w;
        bus.i_upd_b   = tbl[0].b;
        bus.i_start   = 1'b1;
        bus.i_k       = tbl[0].k;
        step();
        check("simul ack", bus.o_upd_ack, 1);
        check("simul rd",  bus.o_rd, 0);
        bus.i_upd_req = 1'b0;
        bus.i_start   = 1'b0;
        nd = 0;
        for (int c = 0; c < 8; c++) begin
            step();
            if (bus.o_done) nd++;
            check($sformatf("simul idle@%0d", c), bus.o_busy, 0);
        end
        check("simul no done", nd, 0);

        // Asynchronous reset in cycle 4 of a pass.
        bus.i_k     = tbl[0].k;
        bus.i_start = 1'b1;
        step();
        bus.i_start = 1'b0;
        repeat (3) step();
        check("pre-abort busy", bus.o_busy, 1);
        rst = 1'b1;
        #1;
        check_zero("abort");
        step();
        rst = 1'b0;
        nd = 0;
        for (int c = 0; c < 10; c++) begin
            step();
            if (bus.o_done) nd++;
            check($sformatf("abort no wr@%0d", c), bus.o_wr, 0);
        end
        check("abort no done", nd, 0);
        run_pass(tbl[0].k, '0, '0, tbl[0].es, tbl[0].ea, 0, "after-abort");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
